// File: rtl/ysyx_22051013_ifu_fetch_pkg.sv
// Shared constants for the IFU fetch slice: opcodes, FSM encodings, PC defaults.
package ysyx_22051013_ifu_fetch_pkg;

  localparam int IFU_PC_W   = 64;
  localparam int IFU_INST_W = 32;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [63:0] PLUS4            = 64'd4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// Instruction-memory request/response bus between the IFU (master) and imem (slave).
interface ysyx_22051013_ifu_fetch_if
  import ysyx_22051013_ifu_fetch_pkg::*;
#(
  parameter int PC_W   = IFU_PC_W,
  parameter int INST_W = IFU_INST_W
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/ysyx_22051013_ifu_fetch_predecode.sv
// Combinational predecode: next fetch PC and taken prediction for a fetched word.
// Backward-branch prediction is enabled by YSYX_22051013_IFU_BPU_EN.
module ysyx_22051013_ifu_fetch_predecode
  import ysyx_22051013_ifu_fetch_pkg::*;
#(
  parameter int PC_W   = IFU_PC_W,
  parameter int INST_W = IFU_INST_W
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   next_pc,
  output logic              pred_taken
);
  logic [6:0]             opc;
  logic signed [20:0]     j_imm;
  logic signed [PC_W-1:0] j_off;
  logic                   unused_inst;

  assign opc         = inst[6:0];
  assign j_imm       = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign j_off       = {{(PC_W-21){j_imm[20]}}, j_imm};
  assign unused_inst = ^inst;

`ifdef YSYX_22051013_IFU_BPU_EN
  logic signed [12:0]     b_imm;
  logic signed [PC_W-1:0] b_off;

  assign b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign b_off = {{(PC_W-13){b_imm[12]}}, b_imm};
`endif

  always_comb begin
    next_pc    = pc + PC_W'(PLUS4);
    pred_taken = 1'b0;
    if (opc == OPC_JAL) begin
      // JAL is redirected locally but is not a prediction
      next_pc = pc + $unsigned(j_off);
    end
`ifdef YSYX_22051013_IFU_BPU_EN
    else if (opc == OPC_BRANCH && inst[31]) begin
      next_pc    = pc + $unsigned(b_off);
      pred_taken = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Fetch stage: PC/FSM, single-outstanding imem requests, IF/ID register with one-entry skid.
// Optional backward-branch prediction via YSYX_22051013_IFU_BPU_EN (in the predecode sub-module).
module ysyx_22051013_ifu_fetch
  import ysyx_22051013_ifu_fetch_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22051013_ifu_fetch_if.master imem,
  input  logic                      id_flush,
  input  logic [PC_W-1:0]           jump_pc,
  input  logic                      id_ready,
  input  logic                      id_stall,
  output logic                      if_valid,
  output logic [PC_W-1:0]           pc_o,
  output logic [INST_W-1:0]         inst_o,
  output logic                      bpu_jump
);
  ifu_state_e        state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic              drop, drop_nxt;
  logic              outstanding, outstanding_nxt;
  logic              if_valid_nxt;
  logic              skid_vld, skid_vld_nxt;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              skid_pred;
  logic              ifid_load, skid_load;
  logic [PC_W-1:0]   ld_pc;
  logic [INST_W-1:0] ld_inst;
  logic              ld_pred;
  logic              fire, ifid_open, rsp, rsp_take;
  logic [PC_W-1:0]   pd_next;
  logic              pd_taken;

  ysyx_22051013_ifu_fetch_predecode #(.PC_W(PC_W), .INST_W(INST_W)) u_predecode (
    .pc         (pc),
    .inst       (imem.imem_rdata),
    .next_pc    (pd_next),
    .pred_taken (pd_taken)
  );

  assign imem.imem_req  = (state == IFU_REQ);
  assign imem.imem_addr = pc;

  assign fire      = if_valid & id_ready & ~id_stall;
  assign ifid_open = ~if_valid | fire;
  // Responses only count while a request is actually outstanding
  assign rsp       = imem.imem_rvalid & outstanding & (state == IFU_WAIT);
  assign rsp_take  = rsp & ~drop & ~id_flush;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drop_nxt        = drop;
    outstanding_nxt = outstanding;
    if_valid_nxt    = if_valid & ~fire;
    skid_vld_nxt    = skid_vld;
    ifid_load       = 1'b0;
    skid_load       = 1'b0;
    ld_pc           = skid_pc;
    ld_inst         = skid_inst;
    ld_pred         = skid_pred;

    if (rsp) outstanding_nxt = 1'b0;
    if (state == IFU_REQ && imem.imem_gnt) outstanding_nxt = 1'b1;

    if (id_flush) begin
      if_valid_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
      pc_nxt       = jump_pc;
      unique case (state)
        IFU_IDLE: state_nxt = IFU_REQ;
        IFU_REQ: begin
          state_nxt = imem.imem_gnt ? IFU_WAIT : IFU_REQ;
          drop_nxt  = imem.imem_gnt;
        end
        IFU_WAIT: begin
          // A response arriving with the flush is itself the one to discard
          state_nxt = rsp ? IFU_REQ : IFU_WAIT;
          drop_nxt  = ~rsp;
        end
        default: state_nxt = IFU_IDLE;
      endcase
    end else begin
      if (skid_vld && ifid_open) begin
        ifid_load    = 1'b1;
        if_valid_nxt = 1'b1;
        skid_vld_nxt = 1'b0;
      end else if (rsp_take && ifid_open) begin
        ifid_load    = 1'b1;
        if_valid_nxt = 1'b1;
        ld_pc        = pc;
        ld_inst      = imem.imem_rdata;
        ld_pred      = pd_taken;
      end else if (rsp_take) begin
        skid_load    = 1'b1;
        skid_vld_nxt = 1'b1;
      end

      unique case (state)
        IFU_IDLE: if (!skid_vld) state_nxt = IFU_REQ;
        IFU_REQ:  if (imem.imem_gnt) state_nxt = IFU_WAIT;
        IFU_WAIT: begin
          if (rsp) begin
            drop_nxt = 1'b0;
            if (drop) begin
              state_nxt = IFU_REQ;
            end else begin
              pc_nxt    = pd_next;
              state_nxt = skid_vld_nxt ? IFU_IDLE : IFU_REQ;
            end
          end
        end
        default: state_nxt = IFU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IFU_IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      outstanding <= 1'b0;
      skid_vld    <= 1'b0;
      if_valid    <= 1'b0;
      pc_o        <= '0;
      inst_o      <= '0;
      bpu_jump    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop        <= drop_nxt;
      outstanding <= outstanding_nxt;
      skid_vld    <= skid_vld_nxt;
      if_valid    <= if_valid_nxt;
      if (ifid_load) begin
        pc_o     <= ld_pc;
        inst_o   <= ld_inst;
        bpu_jump <= ld_pred;
      end
    end
  end

  // Skid payload is qualified by skid_vld, so it carries no reset
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_pc   <= pc;
      skid_inst <= imem.imem_rdata;
      skid_pred <= pd_taken;
    end
  end

endmodule
